flash_byte_fetch: RTL

//  Read-side consumer of the word/byte address pair produced by the address stepper.
//  On each request it performs one Avalon-MM read of a 32-bit flash word, selects the

---
 rtl/flash_byte_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/flash_byte_fetch.sv
// Fetches one byte from a 32-bit Avalon-MM flash word per request.
// FLASH_WORD_CACHE_EN keeps the last word so forward/reverse steps reuse it.
module flash_byte_fetch #(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_word,
  input  logic [1:0]        req_byte,
  output logic              busy,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              fetch_error,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  output logic [5:0]        flash_mem_burstcount,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    HIT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [7:0]        data_q;
  logic              err_q;
  logic              start;
  logic              capture;
  logic              abort;
  logic              hit;

  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [1:0]  l
  );
    logic [7:0] b;
    case (l)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

`ifdef FLASH_WORD_CACHE_EN
  logic [31:0]       cache_word;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_vld;

  assign hit = cache_vld && (req_word == cache_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_word <= '0;
      cache_addr <= '0;
      cache_vld  <= 1'b0;
    end else if (capture) begin
      cache_word <= flash_mem_readdata;
      cache_addr <= addr_q;
      cache_vld  <= 1'b1;
    end else if (abort) begin
      cache_vld  <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          start   = 1'b1;
          state_d = hit ? HIT : ISSUE;
        end
      end
      ISSUE: begin
        if (!flash_mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        // data arriving on the last allowed cycle still wins over the abort
        if (flash_mem_readdatavalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      HIT:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= abort;
      if (state_q == WAIT_DATA) cnt_q <= cnt_q + 1'b1;
      else                      cnt_q <= '0;
      if (start) begin
        addr_q <= req_word;
        lane_q <= req_byte;
      end
      if (capture) data_q <= pick(flash_mem_readdata, lane_q);
`ifdef FLASH_WORD_CACHE_EN
      if (state_q == HIT) data_q <= pick(cache_word, lane_q);
`endif
    end
  end

  assign busy                 = (state_q != IDLE);
  assign byte_valid           = (state_q == DONE);
  assign byte_data            = data_q;
  assign fetch_error          = err_q;
  assign flash_mem_read       = (state_q == ISSUE);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'b1111;
  assign flash_mem_burstcount = 6'd1;

endmodule
